// File: rtl/ntt_input_gather_if.sv
// ntt_input_gather_if
//
// Groups the serial coefficient stream, the flush control and the 16-lane
// vector handshake of the NTT input gatherer into one bundle.
//
// Signals:
//   din_in / din_valid_in / din_ready_out  serial coefficient stream (valid/ready)
//   flush_in                               synchronous abort/clear
//   NTTD0_out .. NTTD15_out                parallel vector lanes
//   vec_valid_out / vec_ack_in             vector handshake to the butterfly core
//   lane_cnt_out                           words already written into the current write bank
//
// Modports:
//   slave  - the gatherer itself
//   master - the environment (stream producer and vector consumer)
interface ntt_input_gather_if #(
    parameter int P_WIDTH = 64
);
    logic [P_WIDTH-1:0] din_in;
    logic               din_valid_in;
    logic               din_ready_out;
    logic               flush_in;
    logic [P_WIDTH-1:0] NTTD0_out;
    logic [P_WIDTH-1:0] NTTD1_out;
    logic [P_WIDTH-1:0] NTTD2_out;
    logic [P_WIDTH-1:0] NTTD3_out;
    logic [P_WIDTH-1:0] NTTD4_out;
    logic [P_WIDTH-1:0] NTTD5_out;
    logic [P_WIDTH-1:0] NTTD6_out;
    logic [P_WIDTH-1:0] NTTD7_out;
    logic [P_WIDTH-1:0] NTTD8_out;
    logic [P_WIDTH-1:0] NTTD9_out;
    logic [P_WIDTH-1:0] NTTD10_out;
    logic [P_WIDTH-1:0] NTTD11_out;
    logic [P_WIDTH-1:0] NTTD12_out;
    logic [P_WIDTH-1:0] NTTD13_out;
    logic [P_WIDTH-1:0] NTTD14_out;
    logic [P_WIDTH-1:0] NTTD15_out;
    logic               vec_valid_out;
    logic               vec_ack_in;
    logic [3:0]         lane_cnt_out;

    modport slave (
        input  din_in, din_valid_in, flush_in, vec_ack_in,
        output din_ready_out, vec_valid_out, lane_cnt_out,
        output NTTD0_out, NTTD1_out, NTTD2_out, NTTD3_out,
        output NTTD4_out, NTTD5_out, NTTD6_out, NTTD7_out,
        output NTTD8_out, NTTD9_out, NTTD10_out, NTTD11_out,
        output NTTD12_out, NTTD13_out, NTTD14_out, NTTD15_out
    );

    modport master (
        output din_in, din_valid_in, flush_in, vec_ack_in,
        input  din_ready_out, vec_valid_out, lane_cnt_out,
        input  NTTD0_out, NTTD1_out, NTTD2_out, NTTD3_out,
        input  NTTD4_out, NTTD5_out, NTTD6_out, NTTD7_out,
        input  NTTD8_out, NTTD9_out, NTTD10_out, NTTD11_out,
        input  NTTD12_out, NTTD13_out, NTTD14_out, NTTD15_out
    );
endinterface

// File: rtl/ntt_input_gather.sv
// ntt_input_gather
//
// Input-side deserializer for the 16-lane NTT datapath. Accepts one
// coefficient per cycle and assembles 16-word vectors in a two-bank
// ping-pong buffer; a completed bank is presented on 16 parallel lanes
// with a valid/ack handshake. One bank can fill while the other is held
// for the consumer, giving 1 word/cycle sustained throughput.
//
// Ports:
//   clk    single clock, rising edge
//   rst_n  asynchronous, active-low reset
//   io     ntt_input_gather_if.slave (stream in, flush, vector out, lane count)
//
// Build option:
//   NTT_GATHER_BITREV_EN  when defined, word k of a vector is stored in lane
//                         bitrev4(k) (bit-reversed order for a DIT core);
//                         otherwise word k goes to lane k.
module ntt_input_gather #(
    parameter int                 P_WIDTH = 64,
    parameter logic [P_WIDTH-1:0] P_ZERO  = '0
) (
    input logic                   clk,
    input logic                   rst_n,
    ntt_input_gather_if.slave     io
);

    // Control state
    logic [1:0] full_q, full_d;
    logic       wbank_q, wbank_d;
    logic       rbank_q, rbank_d;
    logic [3:0] lane_cnt_q, lane_cnt_d;
    logic       run_q, run_d;

    // Ping-pong storage: bank_q[bank][lane]
    logic [P_WIDTH-1:0] bank_q [0:1][0:15];

    logic               din_ready;
    logic               vec_valid;
    logic               accept;
    logic               ack;
    logic               wr_en;
    logic [3:0]         wr_lane;
    logic [P_WIDTH-1:0] lane_data [0:15];

    // Ready depends only on registered state, so an ack can never reach
    // din_ready_out in the same cycle; a freed bank shows up one edge later.
    assign din_ready = run_q & ~full_q[wbank_q];
    assign vec_valid = full_q[rbank_q];
    assign accept    = io.din_valid_in & din_ready;
    // An ack with nothing valid is ignored.
    assign ack       = io.vec_ack_in & vec_valid;
    // Flush wins over a concurrent accept: the word is not stored.
    assign wr_en     = accept & ~io.flush_in;

`ifdef NTT_GATHER_BITREV_EN
    assign wr_lane = {lane_cnt_q[0], lane_cnt_q[1], lane_cnt_q[2], lane_cnt_q[3]};
`else
    assign wr_lane = lane_cnt_q;
`endif

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        full_d     = full_q;
        wbank_d    = wbank_q;
        rbank_d    = rbank_q;
        lane_cnt_d = lane_cnt_q;
        run_d      = 1'b1;

        if (io.flush_in) begin
            full_d     = 2'b00;
            wbank_d    = 1'b0;
            rbank_d    = 1'b0;
            lane_cnt_d = 4'd0;
        end else begin
            if (accept) begin
                if (lane_cnt_q == 4'd15) begin
                    full_d[wbank_q] = 1'b1;
                    wbank_d         = ~wbank_q;
                    lane_cnt_d      = 4'd0;
                end else begin
                    lane_cnt_d = lane_cnt_q + 4'd1;
                end
            end
            // An accept needs full[wbank]=0 and an ack needs full[rbank]=1,
            // so when both happen they touch different banks and both apply.
            if (ack) begin
                full_d[rbank_q] = 1'b0;
                rbank_d         = ~rbank_q;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q     <= 2'b00;
            wbank_q    <= 1'b0;
            rbank_q    <= 1'b0;
            lane_cnt_q <= 4'd0;
            run_q      <= 1'b0;
        end else begin
            full_q     <= full_d;
            wbank_q    <= wbank_d;
            rbank_q    <= rbank_d;
            lane_cnt_q <= lane_cnt_d;
            run_q      <= run_d;
        end
    end

    // NOTE: the data banks are deliberately not reset; stale contents are
    // never visible because the lanes are masked while full[rbank] is 0.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            bank_q[wbank_q][wr_lane] <= io.din_in;
        end
    end

    for (genvar g = 0; g < 16; g++) begin : g_lane
        assign lane_data[g] = vec_valid ? bank_q[rbank_q][g] : P_ZERO;
    end

    assign io.din_ready_out = din_ready;
    assign io.vec_valid_out = vec_valid;
    assign io.lane_cnt_out  = lane_cnt_q;

    assign io.NTTD0_out  = lane_data[0];
    assign io.NTTD1_out  = lane_data[1];
    assign io.NTTD2_out  = lane_data[2];
    assign io.NTTD3_out  = lane_data[3];
    assign io.NTTD4_out  = lane_data[4];
    assign io.NTTD5_out  = lane_data[5];
    assign io.NTTD6_out  = lane_data[6];
    assign io.NTTD7_out  = lane_data[7];
    assign io.NTTD8_out  = lane_data[8];
    assign io.NTTD9_out  = lane_data[9];
    assign io.NTTD10_out = lane_data[10];
    assign io.NTTD11_out = lane_data[11];
    assign io.NTTD12_out = lane_data[12];
    assign io.NTTD13_out = lane_data[13];
    assign io.NTTD14_out = lane_data[14];
    assign io.NTTD15_out = lane_data[15];

endmodule

// File: tb/tb_ntt_input_gather.sv
// tb_ntt_input_gather
//
// Directed bench for ntt_input_gather: reset/startup, single vector,
// backpressure with both banks full, simultaneous fill+ack, stray ack,
// flush mid-fill and with a full bank, and asynchronous reset mid-vector.
// Expected lane positions follow the build option NTT_GATHER_BITREV_EN.
module tb_ntt_input_gather;

    localparam int P_WIDTH = 64;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    ntt_input_gather_if #(.P_WIDTH(P_WIDTH)) bus ();

    ntt_input_gather #(
        .P_WIDTH (P_WIDTH),
        .P_ZERO  ('0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Lane that word k of a vector lands in.
    function automatic int map_idx(input int k);
`ifdef NTT_GATHER_BITREV_EN
        logic [3:0] b;
        b = k[3:0];
        return int'({b[0], b[1], b[2], b[3]});
`else
        return k;
`endif
    endfunction

    function automatic logic [P_WIDTH-1:0] lane(input int k);
        case (k)
            0:  return bus.NTTD0_out;
            1:  return bus.NTTD1_out;
            2:  return bus.NTTD2_out;
            3:  return bus.NTTD3_out;
            4:  return bus.NTTD4_out;
            5:  return bus.NTTD5_out;
            6:  return bus.NTTD6_out;
            7:  return bus.NTTD7_out;
            8:  return bus.NTTD8_out;
            9:  return bus.NTTD9_out;
            10: return bus.NTTD10_out;
            11: return bus.NTTD11_out;
            12: return bus.NTTD12_out;
            13: return bus.NTTD13_out;
            14: return bus.NTTD14_out;
            default: return bus.NTTD15_out;
        endcase
    endfunction

    task automatic check(input string tag, input logic [P_WIDTH-1:0] obs,
                         input logic [P_WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks that word k of the vector (value base+k) sits in lane map(k).
    task automatic check_vector(input string tag, input logic [P_WIDTH-1:0] base);
        for (int k = 0; k < 16; k++) begin
            check($sformatf("%s_w%0d", tag, k), lane(map_idx(k)), base + P_WIDTH'(k));
        end
    endtask

    task automatic check_lanes_zero(input string tag);
        for (int k = 0; k < 16; k++) begin
            check($sformatf("%s_l%0d", tag, k), lane(k), '0);
        end
    endtask

    // Offers one word and waits (bounded) until it is accepted.
    // Called and returns at #1 after a rising edge.
    task automatic push(input logic [P_WIDTH-1:0] data);
        int n;
        n = 0;
        while (!bus.din_ready_out && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!bus.din_ready_out) begin
            check("push_timeout", 64'd0, 64'd1);
        end else begin
            bus.din_in       = data;
            bus.din_valid_in = 1'b1;
            @(posedge clk);
            #1;
            bus.din_valid_in = 1'b0;
        end
    endtask

    task automatic push_n(input logic [P_WIDTH-1:0] base, input int n);
        for (int i = 0; i < n; i++) push(base + P_WIDTH'(i));
    endtask

    task automatic pulse_ack();
        bus.vec_ack_in = 1'b1;
        @(posedge clk);
        #1;
        bus.vec_ack_in = 1'b0;
    endtask

    initial begin
        int acc;
        checks           = 0;
        errors           = 0;
        rst_n            = 1'b0;
        bus.din_in       = '0;
        bus.din_valid_in = 1'b0;
        bus.flush_in     = 1'b0;
        bus.vec_ack_in   = 1'b0;

        // ---- Reset / startup ----
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 64'(bus.din_ready_out), 64'd0);
        check("rst_valid", 64'(bus.vec_valid_out), 64'd0);
        check("rst_lane_cnt", 64'(bus.lane_cnt_out), 64'd0);
        check_lanes_zero("rst_zero");
        rst_n = 1'b1;
        #1;
        check("ready_before_first_edge", 64'(bus.din_ready_out), 64'd0);
        @(posedge clk);
        #1;
        check("ready_after_first_edge", 64'(bus.din_ready_out), 64'd1);
        check("valid_after_first_edge", 64'(bus.vec_valid_out), 64'd0);

        // ---- Single vector ----
        push_n(64'h100, 15);
        check("single_cnt15", 64'(bus.lane_cnt_out), 64'd15);
        check("single_valid_early", 64'(bus.vec_valid_out), 64'd0);
        check_lanes_zero("single_masked");
        push(64'h10F);
        check("single_valid", 64'(bus.vec_valid_out), 64'd1);
        check("single_cnt_wrap", 64'(bus.lane_cnt_out), 64'd0);
        check("single_ready", 64'(bus.din_ready_out), 64'd1);
        check_vector("single", 64'h100);
        pulse_ack();
        check("single_ack_valid", 64'(bus.vec_valid_out), 64'd0);
        check("single_ack_lane0", lane(0), '0);

        // ---- Backpressure: 40 offered, 32 taken ----
        acc = 0;
        for (int i = 0; i < 40; i++) begin
            bus.din_in       = 64'h200 + 64'(i);
            bus.din_valid_in = 1'b1;
            if (bus.din_ready_out) acc++;
            @(posedge clk);
            #1;
        end
        bus.din_valid_in = 1'b0;
        check("bp_accepted", 64'(acc), 64'd32);
        check("bp_ready", 64'(bus.din_ready_out), 64'd0);
        check("bp_lane_cnt", 64'(bus.lane_cnt_out), 64'd0);
        check("bp_valid", 64'(bus.vec_valid_out), 64'd1);
        check_vector("bp_v1", 64'h200);
        bus.vec_ack_in = 1'b1;
        #1;
        check("bp_no_comb_ready", 64'(bus.din_ready_out), 64'd0);
        @(posedge clk);
        #1;
        bus.vec_ack_in = 1'b0;
        check("bp_ready_after_ack", 64'(bus.din_ready_out), 64'd1);
        check("bp_valid_v2", 64'(bus.vec_valid_out), 64'd1);
        check_vector("bp_v2", 64'h210);

        // ---- Simultaneous last accept + ack ----
        push_n(64'h300, 15);
        check("sim_hold_v2", lane(map_idx(3)), 64'h213);
        bus.din_in       = 64'h30F;
        bus.din_valid_in = 1'b1;
        bus.vec_ack_in   = 1'b1;
        check("sim_ready_pre", 64'(bus.din_ready_out), 64'd1);
        @(posedge clk);
        #1;
        bus.din_valid_in = 1'b0;
        bus.vec_ack_in   = 1'b0;
        check("sim_valid", 64'(bus.vec_valid_out), 64'd1);
        check("sim_ready", 64'(bus.din_ready_out), 64'd1);
        check_vector("sim", 64'h300);

        // ---- Stray ack ----
        pulse_ack();
        check("stray_pre_valid", 64'(bus.vec_valid_out), 64'd0);
        pulse_ack();
        check("stray_valid", 64'(bus.vec_valid_out), 64'd0);
        check("stray_lane_cnt", 64'(bus.lane_cnt_out), 64'd0);
        check("stray_ready", 64'(bus.din_ready_out), 64'd1);
        // If the stray ack had toggled rbank, this vector would stay hidden.
        push_n(64'h400, 16);
        check("stray_rbank_valid", 64'(bus.vec_valid_out), 64'd1);
        check_vector("stray", 64'h400);
        pulse_ack();

        // ---- Flush mid-fill ----
        push_n(64'h500, 7);
        check("flush_cnt7", 64'(bus.lane_cnt_out), 64'd7);
        bus.din_in       = 64'h5FF;
        bus.din_valid_in = 1'b1;
        bus.flush_in     = 1'b1;
        @(posedge clk);
        #1;
        bus.din_valid_in = 1'b0;
        bus.flush_in     = 1'b0;
        check("flush_cnt", 64'(bus.lane_cnt_out), 64'd0);
        check("flush_valid", 64'(bus.vec_valid_out), 64'd0);
        check("flush_ready", 64'(bus.din_ready_out), 64'd1);
        push_n(64'h600, 16);
        check("flush_vec_valid", 64'(bus.vec_valid_out), 64'd1);
        check("flush_nttd0", bus.NTTD0_out, 64'h600);
        check_vector("flush_vec", 64'h600);

        // ---- Flush with a complete vector pending ----
        bus.flush_in = 1'b1;
        @(posedge clk);
        #1;
        bus.flush_in = 1'b0;
        check("flush_full_valid", 64'(bus.vec_valid_out), 64'd0);
        check_lanes_zero("flush_full_zero");

        // ---- Asynchronous reset mid-vector ----
        push_n(64'h700, 5);
        check("arst_cnt_pre", 64'(bus.lane_cnt_out), 64'd5);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_cnt", 64'(bus.lane_cnt_out), 64'd0);
        check("arst_ready", 64'(bus.din_ready_out), 64'd0);
        check("arst_valid", 64'(bus.vec_valid_out), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("arst_ready_back", 64'(bus.din_ready_out), 64'd1);
        check("arst_cnt_back", 64'(bus.lane_cnt_out), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
